// File: rtl/datapath_core.sv
// Datapath executing control-unit words: PC/IR, 16-entry register file,
// synchronous data memory and ALU, with IR returned to the control unit.
module datapath_core #(
    parameter int    DATA_W    = 16,
    parameter int    DMEM_AW   = 8,
    parameter string DMEM_INIT = ""
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               PC_CLR,
    input  logic               PC_IC,
    input  logic               IR_LD,
    input  logic [DMEM_AW-1:0] D_ADDR,
    input  logic               D_WR,
    input  logic               RF_S,
    input  logic               RF_W_EN,
    input  logic [3:0]         RF_A_ADDR,
    input  logic [3:0]         RF_B_ADDR,
    input  logic [3:0]         RF_W_ADDR,
    input  logic [3:0]         ALU_S,
    input  logic [DATA_W-1:0]  I_DATA,
    output logic [7:0]         I_ADDR,
    output logic [DATA_W-1:0]  IR,
    output logic [7:0]         PC,
    output logic [DATA_W-1:0]  ALU_Y,
    output logic [2:0]         FLAGS
);

    typedef enum logic [3:0] {
        AluPass = 4'h0,
        AluAdd  = 4'h1,
        AluSub  = 4'h2,
        AluAnd  = 4'h3,
        AluOr   = 4'h4,
        AluXor  = 4'h5,
        AluNand = 4'h6,
        AluShl  = 4'h7,
        AluShr  = 4'h8,
        AluRol  = 4'h9,
        AluRor  = 4'hA
    } aluOp_e;

    logic [7:0]        pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [2:0]        flags_q, flags_d;
    logic [DATA_W-1:0] dRdata_q;
    logic [DATA_W-1:0] regFile_q [16];
    logic [DATA_W-1:0] mem_q [2**DMEM_AW];

    logic [DATA_W-1:0] opA, opB, aluY, rfWData;
    logic              aluC;

    assign opA = regFile_q[RF_A_ADDR];
    assign opB = regFile_q[RF_B_ADDR];

    // Unlisted select codes fall through to pass-A with carry cleared
    always_comb begin
        aluY = opA;
        aluC = 1'b0;
        case (aluOp_e'(ALU_S))
            AluAdd:  {aluC, aluY} = {1'b0, opA} + {1'b0, opB};
            AluSub:  begin
                aluY = opA - opB;
                aluC = (opA < opB);
            end
            AluAnd:  aluY = opA & opB;
            AluOr:   aluY = opA | opB;
            AluXor:  aluY = opA ^ opB;
            AluNand: aluY = ~(opA & opB);
            AluShl:  begin
                aluY = {opA[DATA_W-2:0], 1'b0};
                aluC = opA[DATA_W-1];
            end
            AluShr:  begin
                aluY = {1'b0, opA[DATA_W-1:1]};
                aluC = opA[0];
            end
            AluRol:  begin
                aluY = {opA[DATA_W-2:0], opA[DATA_W-1]};
                aluC = opA[DATA_W-1];
            end
            AluRor:  begin
                aluY = {opA[0], opA[DATA_W-1:1]};
                aluC = opA[0];
            end
            default: ;
        endcase
    end

    // Flags track only ALU writebacks; loads from memory leave them alone
    always_comb begin
        pc_d = pc_q;
        if (PC_CLR)
            pc_d = '0;
        else if (PC_IC)
            pc_d = pc_q + 8'd1;
        ir_d    = IR_LD ? I_DATA : ir_q;
        flags_d = flags_q;
        if (RF_W_EN && !RF_S)
            flags_d = {aluY[DATA_W-1], (aluY == '0), aluC};
        rfWData = RF_S ? dRdata_q : aluY;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_q     <= '0;
            ir_q     <= '0;
            flags_q  <= '0;
            dRdata_q <= '0;
            for (int i = 0; i < 16; i++)
                regFile_q[i] <= '0;
        end else begin
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            flags_q  <= flags_d;
            dRdata_q <= mem_q[D_ADDR];
            if (RF_W_EN)
                regFile_q[RF_W_ADDR] <= rfWData;
        end
    end

    // Memory has no reset, but a write on a reset edge is still suppressed
    always_ff @(posedge Clock) begin
        if (D_WR && !Reset)
            mem_q[D_ADDR] <= opA;
    end

    assign I_ADDR = pc_q;
    assign PC     = pc_q;
    assign IR     = ir_q;
    assign ALU_Y  = aluY;
    assign FLAGS  = flags_q;

endmodule

// File: tb/tb_datapath_core.sv
// Directed, table-driven bench for datapath_core with a behavioural instruction ROM.
module tb_datapath_core;

    logic        Clock = 1'b0;
    logic        Reset, PC_CLR, PC_IC, IR_LD, D_WR, RF_S, RF_W_EN;
    logic [7:0]  D_ADDR;
    logic [3:0]  RF_A_ADDR, RF_B_ADDR, RF_W_ADDR, ALU_S;
    logic [15:0] I_DATA;
    logic [7:0]  I_ADDR, PC;
    logic [15:0] IR, ALU_Y;
    logic [2:0]  FLAGS;

    logic [15:0] rom [256];
    int assertCount = 0;
    int failCount   = 0;

    typedef struct packed {
        logic       pcClr, pcIc, irLd, dWr, rfS, rfWEn;
        logic [7:0] dAddr;
        logic [3:0] a, b, w, aluS;
    } ctrl_t;

    typedef struct {
        logic        pcClr, pcIc, irLd, wEn;
        logic [3:0]  a, b, w, aluS;
        logic        rb;
        logic [7:0]  expPc;
        logic [15:0] expIr, expY;
        logic [2:0]  expFlags;
    } vec_t;

    vec_t t1 [8];
    vec_t t2 [15];

    always #5 Clock = ~Clock;

    assign I_DATA = rom[I_ADDR];

    datapath_core dut (
        .Clock(Clock), .Reset(Reset), .PC_CLR(PC_CLR), .PC_IC(PC_IC), .IR_LD(IR_LD),
        .D_ADDR(D_ADDR), .D_WR(D_WR), .RF_S(RF_S), .RF_W_EN(RF_W_EN),
        .RF_A_ADDR(RF_A_ADDR), .RF_B_ADDR(RF_B_ADDR), .RF_W_ADDR(RF_W_ADDR),
        .ALU_S(ALU_S), .I_DATA(I_DATA), .I_ADDR(I_ADDR), .IR(IR), .PC(PC),
        .ALU_Y(ALU_Y), .FLAGS(FLAGS)
    );

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic driveCtrl(input ctrl_t c, input logic rst);
        Reset     = rst;
        PC_CLR    = c.pcClr;
        PC_IC     = c.pcIc;
        IR_LD     = c.irLd;
        D_WR      = c.dWr;
        RF_S      = c.rfS;
        RF_W_EN   = c.rfWEn;
        D_ADDR    = c.dAddr;
        RF_A_ADDR = c.a;
        RF_B_ADDR = c.b;
        RF_W_ADDR = c.w;
        ALU_S     = c.aluS;
    endtask

    task automatic applyStimulus(input ctrl_t c, input logic rst);
        driveCtrl(c, rst);
        @(posedge Clock);
        #1;
    endtask

    task automatic readReg(input logic [3:0] r, input logic [15:0] expected, input string name);
        ctrl_t c = '0;
        c.a = r;
        driveCtrl(c, 1'b0);
        #1;
        checkOutput(name, ALU_Y, expected);
    endtask

    task automatic runVector(input vec_t v, input string name);
        ctrl_t c = '0;
        c.pcClr = v.pcClr;
        c.pcIc  = v.pcIc;
        c.irLd  = v.irLd;
        c.rfWEn = v.wEn;
        c.a     = v.a;
        c.b     = v.b;
        c.w     = v.w;
        c.aluS  = v.aluS;
        applyStimulus(c, 1'b0);
        checkOutput({name, ".pc"}, {8'h00, PC}, {8'h00, v.expPc});
        checkOutput({name, ".ir"}, IR, v.expIr);
        checkOutput({name, ".y"}, ALU_Y, v.expY);
        checkOutput({name, ".flags"}, {13'h0, FLAGS}, {13'h0, v.expFlags});
    endtask

    task automatic loadReg(input logic [7:0] addr, input logic [3:0] r, input logic [15:0] expected);
        ctrl_t c = '0;
        c.dAddr = addr;
        c.a     = r;
        applyStimulus(c, 1'b0);
        checkOutput($sformatf("load%0d.pending", r), ALU_Y, 16'h0000);
        c.rfS   = 1'b1;
        c.rfWEn = 1'b1;
        c.w     = r;
        applyStimulus(c, 1'b0);
        checkOutput($sformatf("load%0d.done", r), ALU_Y, expected);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ctrl_t c;

        for (int i = 0; i < 256; i++)
            rom[i] = {8'hC0, i[7:0]};
        rom[2] = 16'h1234;

        dut.mem_q[8'h10] = 16'hBEEF;
        dut.mem_q[8'h11] = 16'h7FFF;
        dut.mem_q[8'h12] = 16'h0001;
        dut.mem_q[8'h13] = 16'h00AA;
        dut.mem_q[8'h14] = 16'h8001;
        dut.mem_q[8'h20] = 16'h1111;
        dut.mem_q[8'h30] = 16'h5555;

        // PC / IR sequencing: pcClr pcIc irLd wEn a b w s rb | pc ir y flags
        t1[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'h0, 1'b0, 8'h01, 16'h0000, 16'h0000, 3'b000};
        t1[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'h0, 1'b0, 8'h02, 16'h0000, 16'h0000, 3'b000};
        t1[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'h0, 1'b0, 8'h03, 16'h1234, 16'h0000, 3'b000};
        t1[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'h0, 1'b0, 8'h03, 16'hC003, 16'h0000, 3'b000};
        t1[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'h0, 1'b0, 8'h03, 16'hC003, 16'h0000, 3'b000};
        t1[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'h0, 1'b0, 8'h00, 16'hC003, 16'h0000, 3'b000};
        t1[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'h0, 1'b0, 8'h01, 16'hC003, 16'h0000, 3'b000};
        t1[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'h0, 1'b0, 8'h00, 16'hC003, 16'h0000, 3'b000};

        // ALU writebacks with R1=7FFF R2=0001 R3=BEEF R5=00AA R6=8001
        t2[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd2, 4'd4,  4'h1, 1'b1, 8'h00, 16'hC003, 16'h8000, 3'b100};
        t2[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd1, 4'd7,  4'h2, 1'b0, 8'h00, 16'hC003, 16'h0000, 3'b010};
        t2[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd1, 4'd8,  4'h2, 1'b1, 8'h00, 16'hC003, 16'h8002, 3'b101};
        t2[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd6, 4'd9,  4'h1, 1'b1, 8'h00, 16'hC003, 16'h3EF0, 3'b001};
        t2[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd6, 4'd10, 4'h3, 1'b1, 8'h00, 16'hC003, 16'h8001, 3'b100};
        t2[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd5, 4'd11, 4'h5, 1'b1, 8'h00, 16'hC003, 16'hBE45, 3'b100};
        t2[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 4'd2, 4'd12, 4'h4, 1'b1, 8'h00, 16'hC003, 16'h00AB, 3'b000};
        t2[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 4'd3, 4'd13, 4'h6, 1'b1, 8'h00, 16'hC003, 16'hFF55, 3'b100};
        t2[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 4'd0, 4'd14, 4'h7, 1'b1, 8'h00, 16'hC003, 16'h0002, 3'b001};
        t2[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 4'd0, 4'd15, 4'h8, 1'b1, 8'h00, 16'hC003, 16'h4000, 3'b001};
        t2[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd0, 4'd0,  4'h9, 1'b1, 8'h00, 16'hC003, 16'h7DDF, 3'b001};
        t2[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd6, 4'd0, 4'd7,  4'hA, 1'b0, 8'h00, 16'hC003, 16'hC000, 3'b101};
        t2[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 4'd0, 4'd7,  4'h0, 1'b0, 8'h00, 16'hC003, 16'h00AA, 3'b000};
        t2[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd0, 4'd7,  4'hF, 1'b1, 8'h00, 16'hC003, 16'hBEEF, 3'b100};
        t2[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd2, 4'd7,  4'h1, 1'b0, 8'h00, 16'hC003, 16'h0002, 3'b100};

        // Reset state
        c = '0;
        driveCtrl(c, 1'b1);
        repeat (2) @(posedge Clock);
        #1;
        driveCtrl(c, 1'b0);
        #1;
        checkOutput("reset.pc", {8'h00, PC}, 16'h0000);
        checkOutput("reset.iaddr", {8'h00, I_ADDR}, 16'h0000);
        checkOutput("reset.ir", IR, 16'h0000);
        checkOutput("reset.flags", {13'h0, FLAGS}, 16'h0000);
        checkOutput("reset.r0", ALU_Y, 16'h0000);

        for (int i = 0; i < 8; i++)
            runVector(t1[i], $sformatf("pcir[%0d]", i));

        // Register loads through the two-cycle memory path
        loadReg(8'h10, 4'd3, 16'hBEEF);
        loadReg(8'h11, 4'd1, 16'h7FFF);
        loadReg(8'h12, 4'd2, 16'h0001);
        loadReg(8'h13, 4'd5, 16'h00AA);
        loadReg(8'h14, 4'd6, 16'h8001);
        checkOutput("load.flagsHeld", {13'h0, FLAGS}, 16'h0000);

        for (int i = 0; i < 15; i++)
            runVector(t2[i], $sformatf("alu[%0d]", i));
        for (int i = 0; i < 15; i++)
            if (t2[i].rb)
                readReg(t2[i].w, t2[i].expY, $sformatf("alu[%0d].readback", i));

        // Store then read-during-write and read-after-write of the same address
        c = '0;
        c.dWr = 1'b1; c.dAddr = 8'h20; c.a = 4'd5;
        applyStimulus(c, 1'b0);
        c = '0;
        c.dAddr = 8'h20; c.rfS = 1'b1; c.rfWEn = 1'b1; c.w = 4'd8;
        applyStimulus(c, 1'b0);
        c.w = 4'd9;
        applyStimulus(c, 1'b0);
        readReg(4'd8, 16'h1111, "store.oldData");
        readReg(4'd9, 16'h00AA, "store.newData");

        // PC wrap at 8'hFF
        c = '0;
        c.pcClr = 1'b1;
        applyStimulus(c, 1'b0);
        c = '0;
        c.pcIc = 1'b1;
        for (int i = 0; i < 255; i++)
            applyStimulus(c, 1'b0);
        checkOutput("wrap.pcFF", {8'h00, PC}, 16'h00FF);
        checkOutput("wrap.iaddrFF", {8'h00, I_ADDR}, 16'h00FF);
        applyStimulus(c, 1'b0);
        checkOutput("wrap.pc00", {8'h00, PC}, 16'h0000);
        c.irLd = 1'b1;
        applyStimulus(c, 1'b0);
        checkOutput("preReset.pc", {8'h00, PC}, 16'h0001);
        checkOutput("preReset.ir", IR, 16'hC000);
        checkOutput("preReset.flags", {13'h0, FLAGS}, 16'h0004);

        // Reset lands on the second cycle of a LOAD, alongside PC/IR controls
        c = '0;
        c.dAddr = 8'h30; c.a = 4'd3;
        applyStimulus(c, 1'b0);
        c.rfS = 1'b1; c.rfWEn = 1'b1; c.w = 4'd3; c.pcIc = 1'b1; c.irLd = 1'b1;
        applyStimulus(c, 1'b1);
        checkOutput("midLoad.pc", {8'h00, PC}, 16'h0000);
        checkOutput("midLoad.ir", IR, 16'h0000);
        checkOutput("midLoad.flags", {13'h0, FLAGS}, 16'h0000);
        checkOutput("midLoad.r3", ALU_Y, 16'h0000);

        // Read data register was cleared by reset; memory kept its contents
        c = '0;
        c.dAddr = 8'h30; c.rfS = 1'b1; c.rfWEn = 1'b1; c.w = 4'd4; c.a = 4'd4;
        applyStimulus(c, 1'b0);
        checkOutput("postReset.rdataCleared", ALU_Y, 16'h0000);
        c.w = 4'd5; c.a = 4'd5;
        applyStimulus(c, 1'b0);
        checkOutput("postReset.memKept", ALU_Y, 16'h5555);
        checkOutput("postReset.flags", {13'h0, FLAGS}, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
